// File: rtl/melody_sequencer.sv
// melody_sequencer: plays one of NUM_TUNES software-loaded tunes on a buzzer pin.
//   clk, reset (sync, active low)
//   wr_en/wr_tune/wr_idx/wr_period/wr_dur : note table write port ({period, dur})
//   play_req/play_tune/play_loop          : start (or pre-empt with) a tune
//   stop                                  : abort playback, no done
//   buzzer_out                            : square wave, DUTY_PCT high, period in clk cycles
//   busy / done / note_idx                : playback status
module melody_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int NUM_TUNES = 4,
  parameter int MAX_NOTES = 16,
  parameter int PER_W     = 20,
  parameter int DUR_W     = 12,
  parameter int DUTY_PCT  = 70,
  localparam int TUNE_W   = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1,
  localparam int IDX_W    = $clog2(MAX_NOTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [TUNE_W-1:0] wr_tune,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [PER_W-1:0]  wr_period,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic              play_req,
  input  logic [TUNE_W-1:0] play_tune,
  input  logic              play_loop,
  input  logic              stop,
  output logic              buzzer_out,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  note_idx
);
  localparam int TICKS_PER_MS = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int DCNT_W       = DUR_W + $clog2(TICKS_PER_MS + 1);

  typedef struct packed {
    logic [PER_W-1:0] per;
    logic [DUR_W-1:0] dur;
  } note_t;

  typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;

  note_t tbl [NUM_TUNES][MAX_NOTES];

  state_t            state;
  logic [TUNE_W-1:0] cur_tune;
  logic              loop_r;
  logic [PER_W-1:0]  cur_per, high, pc, pc_nxt;
  logic [DCNT_W-1:0] dcnt;   // cycles left in current note minus one
  logic [IDX_W-1:0]  nxt_idx;
  logic              last_idx, adv;
  note_t             e0, e_first, e_next, ld;

  // High time computed once per note; never 0 so short periods still toggle.
  function automatic logic [PER_W-1:0] hi_of(input logic [PER_W-1:0] p);
    logic [PER_W+6:0] prod;
    prod = {7'd0, p} * (PER_W+7)'(DUTY_PCT);
    prod = prod / (PER_W+7)'(100);
    hi_of = (prod[PER_W-1:0] == '0) ? PER_W'(1) : prod[PER_W-1:0];
  endfunction

  function automatic logic [DCNT_W-1:0] len_of(input logic [DUR_W-1:0] d);
    len_of = DCNT_W'(d) * DCNT_W'(TICKS_PER_MS) - DCNT_W'(1);
  endfunction

  // Table: writes land any time; a playing note holds its own copy in cur_per/dcnt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int t = 0; t < NUM_TUNES; t++)
        for (int i = 0; i < MAX_NOTES; i++)
          tbl[t][i] <= '0;
    end else if (wr_en && int'(wr_tune) < NUM_TUNES) begin
      tbl[wr_tune][wr_idx] <= '{per: wr_period, dur: wr_dur};
    end
  end

  always_comb begin
    nxt_idx  = note_idx + IDX_W'(1);
    last_idx = (note_idx == IDX_W'(MAX_NOTES - 1));
    e0       = tbl[play_tune][0];
    e_first  = tbl[cur_tune][0];
    e_next   = tbl[cur_tune][nxt_idx];
    adv      = !last_idx && (e_next.dur != '0);
    pc_nxt   = (pc == cur_per - PER_W'(1)) ? '0 : pc + PER_W'(1);
    // Entry to load on a note start: new request, next entry, or loop wrap.
    if (play_req)  ld = e0;
    else if (adv)  ld = e_next;
    else           ld = e_first;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cur_tune   <= '0;
      loop_r     <= 1'b0;
      cur_per    <= '0;
      high       <= '0;
      pc         <= '0;
      dcnt       <= '0;
      note_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      buzzer_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        buzzer_out <= 1'b0;
      end else if (play_req) begin
        cur_tune <= play_tune;
        loop_r   <= play_loop;
        note_idx <= '0;
        if (e0.dur != '0) begin
          state      <= PLAY;
          busy       <= 1'b1;
          cur_per    <= ld.per;
          high       <= hi_of(ld.per);
          pc         <= '0;
          dcnt       <= len_of(ld.dur);
          buzzer_out <= (ld.per >= PER_W'(2));
        end else begin
          state      <= FINISH;
          busy       <= 1'b0;
          buzzer_out <= 1'b0;
          done       <= 1'b1;
        end
      end else begin
        case (state)
          PLAY: begin
            if (dcnt == '0) begin
              if (adv || (loop_r && e_first.dur != '0)) begin
                note_idx   <= adv ? nxt_idx : '0;
                cur_per    <= ld.per;
                high       <= hi_of(ld.per);
                pc         <= '0;
                dcnt       <= len_of(ld.dur);
                buzzer_out <= (ld.per >= PER_W'(2));
              end else begin
                state      <= FINISH;
                busy       <= 1'b0;
                buzzer_out <= 1'b0;
                done       <= 1'b1;
              end
            end else begin
              dcnt       <= dcnt - DCNT_W'(1);
              pc         <= pc_nxt;
              buzzer_out <= (cur_per >= PER_W'(2)) && (pc_nxt < high);
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer at CLK_HZ=10_000 (10 cycles per ms).
// Inputs change and outputs are sampled on the falling edge.
module tb_melody_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_tune = '0;
  logic [3:0]  wr_idx = '0;
  logic [19:0] wr_period = '0;
  logic [11:0] wr_dur = '0;
  logic        play_req = 1'b0;
  logic [1:0]  play_tune = '0;
  logic        play_loop = 1'b0;
  logic        stop = 1'b0;
  logic        buzzer_out, busy, done;
  logic [3:0]  note_idx;

  int checks = 0;
  int errors = 0;
  int sh_per [4][16];
  int sh_dur [4][16];

  melody_sequencer #(.CLK_HZ(10_000), .NUM_TUNES(4), .MAX_NOTES(16),
                     .PER_W(20), .DUR_W(12), .DUTY_PCT(70)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_tune(wr_tune), .wr_idx(wr_idx),
    .wr_period(wr_period), .wr_dur(wr_dur), .play_req(play_req), .play_tune(play_tune),
    .play_loop(play_loop), .stop(stop), .buzzer_out(buzzer_out), .busy(busy),
    .done(done), .note_idx(note_idx));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // expected buzzer level k cycles into a note of period p
  function automatic bit bz_of(input int p, input int k);
    int hi;
    hi = (p * 70) / 100;
    if (hi < 1) hi = 1;
    return (p >= 2) && ((k % p) < hi);
  endfunction

  task automatic wr(input int t, input int i, input int p, input int d);
    wr_en = 1'b1; wr_tune = 2'(t); wr_idx = 4'(i); wr_period = 20'(p); wr_dur = 12'(d);
    step();
    wr_en = 1'b0;
    sh_per[t][i] = p; sh_dur[t][i] = d;
  endtask

  task automatic play(input int t, input bit lp);
    play_tune = 2'(t); play_loop = lp; play_req = 1'b1;
    step();
    play_req = 1'b0;
  endtask

  // Play a non-looping tune to completion, checking each note's waveform and index.
  task automatic play_chk(input string tag, input int t);
    logic [63:0] obs, exp;
    int idx_bad, i;
    play(t, 1'b0);
    chk({tag, "_busy"}, busy, 1);
    i = 0;
    while (i < 16 && sh_dur[t][i] != 0) begin
      obs = '0; exp = '0; idx_bad = 0;
      for (int k = 0; k < sh_dur[t][i] * 10; k++) begin
        obs[k] = buzzer_out;
        exp[k] = bz_of(sh_per[t][i], k);
        if (note_idx != 4'(i) || !busy || done) idx_bad++;
        step();
      end
      chk($sformatf("%s_bz%0d", tag, i), obs, exp);
      chk($sformatf("%s_idx%0d", tag, i), idx_bad, 0);
      i++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_endbusy"}, busy, 0);
    chk({tag, "_endbz"}, buzzer_out, 0);
    step();
    chk({tag, "_done0"}, done, 0);
  endtask

  initial begin : main
    logic [63:0] obs, exp;
    int dn, cnt;
    logic [3:0] ia, ib;
    logic bb;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 16; i++) begin sh_per[t][i] = 0; sh_dur[t][i] = 0; end

    step(); step();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_bz", buzzer_out, 0); chk("rst_idx", note_idx, 0);
    reset = 1'b1;
    step();

    // basic two-note tune
    wr(1, 0, 10, 2); wr(1, 1, 20, 1);
    play_chk("t1", 1);

    // rest between tones
    wr(2, 0, 10, 1); wr(2, 1, 0, 3); wr(2, 2, 8, 1);
    play_chk("rest", 2);

    // all 16 entries used
    for (int i = 0; i < 16; i++) wr(3, i, 2 + i, 1);
    play_chk("full", 3);

    // empty tune: immediate done, never busy
    play(0, 1'b0);
    chk("empty_done", done, 1); chk("empty_busy", busy, 0);
    step();
    chk("empty_done0", done, 0); chk("empty_busy0", busy, 0);

    // loop, stop after 2.5 iterations (30 cycles each)
    play(1, 1'b1);
    dn = 0; ia = '0; ib = '0; bb = 1'b0;
    for (int t = 0; t < 75; t++) begin
      if (done) dn++;
      if (t == 29) ia = note_idx;
      if (t == 30) begin ib = note_idx; bb = buzzer_out; end
      if (t == 74) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    chk("loop_idx29", ia, 1); chk("loop_idx30", ib, 0); chk("loop_bz30", bb, 1);
    chk("loop_nodone", dn, 0);
    chk("stop_busy", busy, 0); chk("stop_bz", buzzer_out, 0); chk("stop_done", done, 0);
    step();

    // pre-empt tune 1 mid-note with tune 2 (50 cycles total)
    play(1, 1'b0);
    repeat (5) step();
    play(2, 1'b0);
    chk("pre_busy", busy, 1); chk("pre_idx", note_idx, 0); chk("pre_bz", buzzer_out, 1);
    cnt = 0;
    while (!done && cnt < 200) begin step(); cnt++; end
    chk("pre_len", cnt, 50);
    step();

    // stop wins over play_req
    play_req = 1'b1; stop = 1'b1; play_tune = 2'd1;
    step();
    play_req = 1'b0; stop = 1'b0;
    chk("sp_busy", busy, 0);
    step(); step();
    chk("sp_busy2", busy, 0); chk("sp_done", done, 0);

    // overwrite playing entry of a looping tune: old values this pass, new next pass
    play(1, 1'b1);
    obs = '0; exp = '0;
    for (int t = 0; t < 50; t++) begin
      if (t < 20) begin obs[t] = buzzer_out; exp[t] = bz_of(10, t); end
      if (t >= 30) begin obs[t] = buzzer_out; exp[t] = bz_of(4, t - 30); end
      if (t == 5) begin
        wr_en = 1'b1; wr_tune = 2'd1; wr_idx = 4'd0; wr_period = 20'd4; wr_dur = 12'd2;
      end else wr_en = 1'b0;
      if (t == 49) stop = 1'b1;
      step();
    end
    wr_en = 1'b0; stop = 1'b0;
    sh_per[1][0] = 4;
    chk("ovw_bz", obs, exp);
    step();

    // reset mid-note clears outputs and the table
    play(1, 1'b0);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("mrst_busy", busy, 0); chk("mrst_bz", buzzer_out, 0);
    chk("mrst_idx", note_idx, 0); chk("mrst_done", done, 0);
    reset = 1'b1;
    step();
    play(1, 1'b0);
    chk("mrst_pdone", done, 1); chk("mrst_pbusy", busy, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
